div_unit: RTL
=============

# div_unit

Multi-cycle 32-bit integer divider for the MIPS32 DIV/DIVU instructions. It sits beside the execute stage and consumes the operands that the execute stage receives from the ID/EX pipeline register. The execute stage starts a division, holds the pipeline stalled until `ready_o` rises, then writes `result_o` into HI/LO. The divider is radix-2 restoring: one quotient bit per cycle, with signed operands normalised to magnitudes before the loop and the signs fixed up afterwards.

## Interface
Parameters: none; the datapath is fixed at 32-bit operands and a 64-bit result.

Reset and clock (already decided): reset `rst`, synchronous, active-high; clock `clk`.

- `clk`  in  1  clock; all state changes on its rising edge
- `rst`  in  1  synchronous active-high reset
- `signed_div_i`  in  1  1 = DIV (signed), 0 = DIVU (unsigned); sampled with `start_i`
- `opdata1_i`  in  32  dividend; sampled with `start_i`
- `opdata2_i`  in  32  divisor; sampled with `start_i`
- `start_i`  in  1  request; held high by the execute stage until it has consumed the result
- `annul_i`  in  1  cancel the operation in flight (flush or exception)
- `result_o`  out  64  bits [63:32] = remainder (HI), bits [31:0] = quotient (LO); valid only while `ready_o` is high
- `ready_o`  out  1  result valid

## Operation
States: `FREE`, `BYZERO`, `ON`, `END`. Internal registers:
- `cnt`: 6-bit cycle counter
- `dividend`: 65-bit shift register holding the partial remainder and quotient
- `divisor`: 32-bit magnitude
- `sign_q`, `sign_r`: latched sign flags

**Reset:** state `FREE`, `ready_o` = 0, `result_o` = 0, `cnt` = 0. Reset mid-operation aborts the operation and gives exactly the same values.

**`FREE`:** `ready_o` = 0, `result_o` = 0.
- `start_i` = 1, `annul_i` = 0, `opdata2_i` = 0: go to `BYZERO`.
- `start_i` = 1, `annul_i` = 0, `opdata2_i` ≠ 0: go to `ON`.
  - Latch `|opdata1_i|` and `|opdata2_i|`; take the two's-complement magnitude only when `signed_div_i` = 1 and the operand's bit 31 = 1.
  - `sign_q` = `signed_div_i & (op1[31] ^ op2[31])`.
  - `sign_r` = `signed_div_i & op1[31]`.
  - `dividend` = {32'b0, |op1|, 1'b0}; `cnt` = 0.
- Otherwise stay in `FREE`.

**`BYZERO`:** next edge goes to `END` with `result_o` = 0. With `annul_i` = 1 it goes to `FREE` instead.

**`ON`:**
- `annul_i` = 1: go to `FREE` and discard all state; `ready_o` never asserts for this operation.
- `cnt` < 32: compute `diff` = `dividend[63:32]` − `divisor` as a 33-bit subtraction.
  - `diff` negative: `dividend` = `dividend << 1`.
  - Otherwise: `dividend` = {`diff[31:0]`, `dividend[31:0]`, 1'b1}.
  - `cnt` increments by 1.
- `cnt` = 32: quotient `q` = `dividend[31:0]`, remainder `r` = `dividend[64:33]`.
  - `result_o` = {`sign_r` ? −r : r, `sign_q` ? −q : q}; both negations are 32-bit two's complement.
  - Go to `END`.

**`END`:**
- `ready_o` = 1 and `result_o` is held.
- `start_i` = 0: go to `FREE`; `ready_o` and `result_o` clear on that edge.
- `annul_i` is ignored in `END`.
- `start_i` held at 1 keeps the divider in `END` indefinitely; it does not restart.

**Arithmetic rules:**
- Quotient truncates toward zero; the remainder takes the sign of the dividend (MIPS semantics).
- 0x80000000 / −1 signed yields q = 0x80000000, r = 0; this is wrap, not a trap.
- Dividend magnitude of 0x80000000 is represented exactly as an unsigned 32-bit value.

## Timing
- `start_i` sampled at edge E0:
  - Edges E1..E32 perform the 32 iterations.
  - Edge E33 finalises.
  - `ready_o` is high from after E33: 33 cycles of latency.
- Divide by zero: `ready_o` is high after E1, one cycle of latency.
- Operand or `signed_div_i` changes after E0 have no effect.
- `annul_i` sampled on any edge while in `ON` or `BYZERO` takes priority over all progress.
- Back-to-back operations: after `start_i` falls, at least one cycle is spent in `FREE`. A new `start_i` is accepted on the first edge at which the state is `FREE`.
- `result_o` and `ready_o` are registered outputs; no combinational path from inputs.

## Test plan
- DIVU 100 / 7, start held → after 33 cycles `ready_o` = 1, `result_o` = {32'd2, 32'd14}; `start_i` low → next cycle `ready_o` = 0, `result_o` = 0.
- DIV −7 / 2 (0xFFFFFFF9 / 0x2) → `result_o` = {0xFFFFFFFF, 0xFFFFFFFD}; DIV 7 / −2 → {0x00000001, 0xFFFFFFFD}.
- DIV 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}; DIVU 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- Divisor 0, start at E0 → `ready_o` = 1 after E1, `result_o` = 0.
- Start DIVU 1000 / 3, assert `annul_i` for one cycle at E10 → `ready_o` stays 0 for 40 cycles; a fresh DIVU 9 / 3 then gives {0, 3} at 33 cycles of latency.
- Assert `rst` at E15 of an operation → next cycle `FREE`, outputs 0; changing operands after E0 in a normal run does not alter the result.

Source files
------------

// File: rtl/div_unit.sv
// Radix-2 restoring divider for MIPS32 DIV/DIVU: one quotient bit per cycle,
// signed operands handled as magnitudes with sign fix-up on the final edge.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic [1:0]  debug_state
);

    // Handshake: start_i is held high until the result has been consumed;
    // ready_o/result_o are valid together and stay valid while start_i is
    // high; dropping start_i returns the unit to FREE on the next edge.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [5:0]  cnt;
    logic [64:0] dividend;
    logic [31:0] divisor;
    logic        sign_q;
    logic        sign_r;

    logic [31:0] op1_mag;
    logic [31:0] op2_mag;
    logic [32:0] diff;
    logic [31:0] q_raw;
    logic [31:0] r_raw;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic        accept;

    assign debug_state = state;

    // 0x80000000 negates to itself, which is its correct unsigned magnitude.
    assign op1_mag = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign op2_mag = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    assign accept  = start_i && !annul_i;

    assign diff  = {1'b0, dividend[63:32]} - {1'b0, divisor};
    assign q_raw = dividend[31:0];
    assign r_raw = dividend[64:33];
    assign q_fix = sign_q ? (~q_raw + 32'd1) : q_raw;
    assign r_fix = sign_r ? (~r_raw + 32'd1) : r_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FREE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FREE: begin
                if (accept) begin
                    state_next = (opdata2_i == 32'd0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                state_next = annul_i ? FREE : END;
            end
            ON: begin
                if (annul_i) begin
                    state_next = FREE;
                end else if (cnt == 6'd32) begin
                    state_next = END;
                end
            end
            END: begin
                if (!start_i) begin
                    state_next = FREE;
                end
            end
            default: state_next = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 6'd0;
            dividend <= 65'd0;
            divisor  <= 32'd0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
        end else begin
            ready_o <= (state_next == END);
            case (state)
                FREE: begin
                    result_o <= 64'd0;
                    if (accept && (opdata2_i != 32'd0)) begin
                        dividend <= {32'd0, op1_mag, 1'b0};
                        divisor  <= op2_mag;
                        sign_q   <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        sign_r   <= signed_div_i & opdata1_i[31];
                        cnt      <= 6'd0;
                    end
                end
                BYZERO: begin
                    result_o <= 64'd0;
                end
                ON: begin
                    if (annul_i) begin
                        cnt      <= 6'd0;
                        dividend <= 65'd0;
                        divisor  <= 32'd0;
                        sign_q   <= 1'b0;
                        sign_r   <= 1'b0;
                        result_o <= 64'd0;
                    end else if (cnt != 6'd32) begin
                        if (diff[32]) begin
                            dividend <= {dividend[63:0], 1'b0};
                        end else begin
                            dividend <= {diff[31:0], dividend[31:0], 1'b1};
                        end
                        cnt <= cnt + 6'd1;
                    end else begin
                        result_o <= {r_fix, q_fix};
                    end
                end
                END: begin
                    if (!start_i) begin
                        result_o <= 64'd0;
                    end
                end
                default: begin
                    result_o <= 64'd0;
                end
            endcase
        end
    end

endmodule
